// File: rtl/exc_pkg.sv
// Shared definitions for the exception sequencer: cause codes, FSM states,
// default vector-table addresses and the cause priority encoder.
package exc_pkg;

   localparam logic [1:0] CAUSE_NONE  = 2'b00;
   localparam logic [1:0] CAUSE_INVOP = 2'b01;
   localparam logic [1:0] CAUSE_OVF   = 2'b10;
   localparam logic [1:0] CAUSE_DIVZ  = 2'b11;

   localparam logic [31:0] VEC_INVOP_DEF = 32'h0000_00FD;
   localparam logic [31:0] VEC_OVF_DEF   = 32'h0000_00FE;
   localparam logic [31:0] VEC_DIVZ_DEF  = 32'h0000_00FF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SAVE = 2'd1,
      ST_READ = 2'd2,
      ST_DONE = 2'd3
   } exc_state_t;

   // Invalid opcode outranks overflow, which outranks divide-by-zero.
   function automatic logic [1:0] prio_cause(input logic invop, input logic ovf, input logic divz);
      logic [1:0] c;
      if (invop)
         c = CAUSE_INVOP;
      else if (ovf)
         c = CAUSE_OVF;
      else if (divz)
         c = CAUSE_DIVZ;
      else
         c = CAUSE_NONE;
      return c;
   endfunction

endpackage

// File: rtl/exception_unit.sv
// Multicycle exception sequencer: saves EPC, fetches the handler byte from the
// vector table and pulses exc_done. Optional feature macro: EXC_PENDING_EN.
import exc_pkg::*;

module exception_unit #(
   parameter int          MEM_LAT   = 2,
   parameter logic [31:0] VEC_INVOP = VEC_INVOP_DEF,
   parameter logic [31:0] VEC_OVF   = VEC_OVF_DEF,
   parameter logic [31:0] VEC_DIVZ  = VEC_DIVZ_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc_in,
   input  logic        invop,
   input  logic        ovf,
   input  logic        divz,
   input  logic [31:0] mem_data,
   output logic        mem_rd,
   output logic [31:0] mem_addr,
   output logic [31:0] epc_out,
   output logic [31:0] handler_out,
   output logic [1:0]  cause_out,
   output logic        busy,
   output logic        exc_done
);

   localparam logic [2:0] LAT_C = 3'(MEM_LAT);

   exc_state_t  state_r;
   logic [2:0]  cnt_r;
   logic [1:0]  req_cause_s;
   logic [1:0]  next_cause_s;
   logic [31:0] vec_s;
   logic        unused_mem_s;

   assign req_cause_s  = prio_cause(invop, ovf, divz);
   assign unused_mem_s = ^mem_data[31:8];

   // Vector-table address for the cause latched on entry to SAVE.
   always_comb begin
      vec_s = 32'h0000_0000;
      case (cause_out)
         CAUSE_INVOP: vec_s = VEC_INVOP;
         CAUSE_OVF:   vec_s = VEC_OVF;
         CAUSE_DIVZ:  vec_s = VEC_DIVZ;
         default:     vec_s = 32'h0000_0000;
      endcase
   end

`ifdef EXC_PENDING_EN
   logic       pend_valid_r;
   logic [1:0] pend_cause_r;

   // One-deep pending slot: first request seen while busy wins; DONE consumes it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_valid_r <= 1'b0;
         pend_cause_r <= CAUSE_NONE;
      end else if (state_r == ST_DONE) begin
         pend_valid_r <= 1'b0;
         pend_cause_r <= CAUSE_NONE;
      end else if ((state_r != ST_IDLE) && (req_cause_s != CAUSE_NONE) && !pend_valid_r) begin
         pend_valid_r <= 1'b1;
         pend_cause_r <= req_cause_s;
      end
   end

   // A request landing in the DONE cycle itself is chained directly as well.
   assign next_cause_s = pend_valid_r ? pend_cause_r : req_cause_s;
`else
   assign next_cause_s = CAUSE_NONE;
`endif

   // Sequencer FSM with all outputs registered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         cnt_r       <= 3'd0;
         mem_rd      <= 1'b0;
         mem_addr    <= 32'h0000_0000;
         epc_out     <= 32'h0000_0000;
         handler_out <= 32'h0000_0000;
         cause_out   <= CAUSE_NONE;
         busy        <= 1'b0;
         exc_done    <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (req_cause_s != CAUSE_NONE) begin
                  cause_out <= req_cause_s;
                  busy      <= 1'b1;
                  state_r   <= ST_SAVE;
               end
            end
            ST_SAVE: begin
               epc_out  <= pc_in - 32'd4;
               mem_addr <= vec_s;
               mem_rd   <= 1'b1;
               cnt_r    <= 3'd0;
               state_r  <= ST_READ;
            end
            ST_READ: begin
               // Data is valid MEM_LAT cycles after mem_rd rose; capture then.
               if (cnt_r == LAT_C) begin
                  handler_out <= {24'h00_0000, mem_data[7:0]};
                  mem_rd      <= 1'b0;
                  exc_done    <= 1'b1;
                  state_r     <= ST_DONE;
               end else begin
                  cnt_r <= cnt_r + 3'd1;
               end
            end
            ST_DONE: begin
               exc_done <= 1'b0;
               if (next_cause_s != CAUSE_NONE) begin
                  cause_out <= next_cause_s;
                  state_r   <= ST_SAVE;
               end else begin
                  busy    <= 1'b0;
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy    <= 1'b0;
               mem_rd  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_exception_unit.sv
// Directed self-checking bench for exception_unit (MEM_LAT = 2, plus 1 and 7 variants).
module tb_exception_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc_in;
   logic        invop, ovf, divz;
   logic [31:0] mem_data;

   logic        mem_rd[3];
   logic [31:0] mem_addr[3];
   logic [31:0] epc_out[3];
   logic [31:0] handler_out[3];
   logic [1:0]  cause_out[3];
   logic        busy[3];
   logic        exc_done[3];

   int errors = 0;
   int checks = 0;
   int first_k, second_k, ndone;

   always #5 clk = ~clk;

   exception_unit #(.MEM_LAT(2)) u_lat2 (
      .clk(clk), .reset(reset), .pc_in(pc_in), .invop(invop), .ovf(ovf), .divz(divz),
      .mem_data(mem_data), .mem_rd(mem_rd[0]), .mem_addr(mem_addr[0]), .epc_out(epc_out[0]),
      .handler_out(handler_out[0]), .cause_out(cause_out[0]), .busy(busy[0]), .exc_done(exc_done[0]));

   exception_unit #(.MEM_LAT(1)) u_lat1 (
      .clk(clk), .reset(reset), .pc_in(pc_in), .invop(invop), .ovf(ovf), .divz(divz),
      .mem_data(mem_data), .mem_rd(mem_rd[1]), .mem_addr(mem_addr[1]), .epc_out(epc_out[1]),
      .handler_out(handler_out[1]), .cause_out(cause_out[1]), .busy(busy[1]), .exc_done(exc_done[1]));

   exception_unit #(.MEM_LAT(7)) u_lat7 (
      .clk(clk), .reset(reset), .pc_in(pc_in), .invop(invop), .ovf(ovf), .divz(divz),
      .mem_data(mem_data), .mem_rd(mem_rd[2]), .mem_addr(mem_addr[2]), .epc_out(epc_out[2]),
      .handler_out(handler_out[2]), .cause_out(cause_out[2]), .busy(busy[2]), .exc_done(exc_done[2]));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Pulse r1 at k=0 and r2 at k=k2, watch exc_done of the MEM_LAT=2 unit for ncyc cycles.
   task automatic run(input logic [2:0] r1, input logic [2:0] r2, input int k2, input int ncyc);
      first_k  = -1;
      second_k = -1;
      ndone    = 0;
      {invop, ovf, divz} = r1;
      for (int k = 1; k <= ncyc; k++) begin
         tick();
         if (exc_done[0]) begin
            if (ndone == 0) first_k = k;
            else if (ndone == 1) second_k = k;
            ndone++;
         end
         {invop, ovf, divz} = (k == k2) ? r2 : 3'b000;
      end
   endtask

   int rd_cnt[3];
   int rd_first[3];
   int done_k7;

   initial begin
      reset = 1'b1;
      pc_in = 32'h0;
      {invop, ovf, divz} = 3'b000;
      mem_data = 32'h0;
      tick();
      tick();
      chk("rst_mem_rd",   {31'd0, mem_rd[0]},   32'd0);
      chk("rst_busy",     {31'd0, busy[0]},     32'd0);
      chk("rst_done",     {31'd0, exc_done[0]}, 32'd0);
      chk("rst_epc",      epc_out[0],           32'd0);
      chk("rst_handler",  handler_out[0],       32'd0);
      chk("rst_mem_addr", mem_addr[0],          32'd0);
      chk("rst_cause",    {30'd0, cause_out[0]}, 32'd0);
      reset = 1'b0;
      tick();

      // 1: overflow
      pc_in = 32'h40;
      mem_data = 32'h0000_00A5;
      run(3'b010, 3'b000, 0, 25);
      chk("t1_done_k",   first_k,        32'd5);
      chk("t1_ndone",    ndone,          32'd1);
      chk("t1_epc",      epc_out[0],     32'h3C);
      chk("t1_mem_addr", mem_addr[0],    32'hFE);
      chk("t1_handler",  handler_out[0], 32'hA5);
      chk("t1_cause",    {30'd0, cause_out[0]}, 32'd2);
      chk("t1_busy_end", {31'd0, busy[0]}, 32'd0);

      // 2: invop and divz together
      pc_in = 32'h100;
      mem_data = 32'h0000_0033;
      run(3'b101, 3'b000, 0, 25);
      chk("t2_done_k",   first_k,     32'd5);
      chk("t2_ndone",    ndone,       32'd1);
      chk("t2_cause",    {30'd0, cause_out[0]}, 32'd1);
      chk("t2_mem_addr", mem_addr[0], 32'hFD);
      chk("t2_epc",      epc_out[0],  32'hFC);

      // 3: divz with pc_in = 0
      pc_in = 32'h0;
      mem_data = 32'hFFFF_FF12;
      run(3'b001, 3'b000, 0, 25);
      chk("t3_epc",      epc_out[0],     32'hFFFF_FFFC);
      chk("t3_mem_addr", mem_addr[0],    32'hFF);
      chk("t3_handler",  handler_out[0], 32'h12);
      chk("t3_cause",    {30'd0, cause_out[0]}, 32'd3);

      // 4: ovf then divz two cycles later
      pc_in = 32'h200;
      mem_data = 32'h0000_0077;
      run(3'b010, 3'b001, 2, 25);
      chk("t4_first_k", first_k, 32'd5);
`ifdef EXC_PENDING_EN
      chk("t4_ndone",    ndone,       32'd2);
      chk("t4_second_k", second_k,    32'd10);
      chk("t4_cause",    {30'd0, cause_out[0]}, 32'd3);
      chk("t4_mem_addr", mem_addr[0], 32'hFF);
`else
      chk("t4_ndone",    ndone,       32'd1);
      chk("t4_cause",    {30'd0, cause_out[0]}, 32'd2);
      chk("t4_mem_addr", mem_addr[0], 32'hFE);
`endif

      // 5: reset in the middle of READ
      pc_in = 32'h300;
      ovf = 1'b1;
      tick();
      ovf = 1'b0;
      tick();
      tick();
      chk("t5_rd_before", {31'd0, mem_rd[0]}, 32'd1);
      reset = 1'b1;
      #1;
      chk("t5_rd_rst",   {31'd0, mem_rd[0]}, 32'd0);
      chk("t5_busy_rst", {31'd0, busy[0]},   32'd0);
      chk("t5_epc_rst",  epc_out[0],         32'd0);
      tick();
      reset = 1'b0;
      tick();
      pc_in = 32'h80;
      mem_data = 32'h0000_0034;
      run(3'b001, 3'b000, 0, 25);
      chk("t5_done_k",  first_k,        32'd5);
      chk("t5_epc",     epc_out[0],     32'h7C);
      chk("t5_handler", handler_out[0], 32'h34);

      // 6: read window and capture point for MEM_LAT 1, 2, 7
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      done_k7 = -1;
      for (int d = 0; d < 3; d++) begin
         rd_cnt[d]   = 0;
         rd_first[d] = -1;
      end
      mem_data = 32'hA0;
      invop = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         tick();
         invop = 1'b0;
         for (int d = 0; d < 3; d++) begin
            if (mem_rd[d]) begin
               if (rd_first[d] < 0) rd_first[d] = k;
               rd_cnt[d]++;
            end
         end
         if (exc_done[2] && done_k7 < 0) done_k7 = k;
         mem_data = 32'hA0 + k;
      end
      chk("t6_rd_cnt_l2",   rd_cnt[0],   32'd3);
      chk("t6_rd_cnt_l1",   rd_cnt[1],   32'd2);
      chk("t6_rd_cnt_l7",   rd_cnt[2],   32'd8);
      chk("t6_rd_first_l1", rd_first[1], 32'd2);
      chk("t6_rd_first_l7", rd_first[2], 32'd2);
      chk("t6_handler_l2",  handler_out[0], 32'hA4);
      chk("t6_handler_l1",  handler_out[1], 32'hA3);
      chk("t6_handler_l7",  handler_out[2], 32'hA9);
      chk("t6_done_k_l7",   done_k7,        32'd10);
      chk("t6_addr_l7",     mem_addr[2],    32'hFD);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
